// File: rtl/rvj1_defines.sv
// Shared constants, types and helpers for the rvj1 core front end.
package rvj1_defines;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_BOOT_ADDR = 32'h8000_0000;

    // One instruction buffer entry: fetched word plus the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ibuf_entry_t;

    // Clear the byte-offset bits so the address points at a whole word.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN - 2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/rvj1_fifo.sv
// Parametric synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module rvj1_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Accepted push/pop; a full buffer takes a push only when the head leaves the same cycle.
    always_comb begin
        do_pop_s  = pop_i & (count_r != {CW{1'b0}});
        do_push_s = push_i & ((count_r != CW'(DEPTH)) | do_pop_s);
    end

    // Storage write; contents need no reset because occupancy is tracked by the count.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout_o  = mem_r[rd_ptr_r];
    assign full_o  = (count_r == CW'(DEPTH));
    assign empty_o = (count_r == {CW{1'b0}});
    assign count_o = count_r;

endmodule

// File: rtl/rvj1_ifu.sv
// Instruction fetch unit: sequential fetch, credit-limited requests,
// buffered delivery to the decoder and redirect handling.
module rvj1_ifu
    import rvj1_defines::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            jmp_instr_i,
    input  logic [XLEN-1:0] jmp_addr_i,
    output logic [XLEN-1:0] ifu_instr_o,
    output logic [XLEN-1:0] ifu_pc_o,
    output logic            ifu_valid_o,
    input  logic            ifu_ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_r;
    logic [CW-1:0]   outst_r;
    logic [CW-1:0]   discard_r;
    logic [CW-1:0]   outst_next_s;

    logic gnt_s;
    logic rsp_s;
    logic drop_s;
    logic push_s;
    logic pop_s;

    ibuf_entry_t     ibuf_din_s;
    ibuf_entry_t     ibuf_dout_s;
    logic            ibuf_full_s;
    logic            ibuf_empty_s;
    logic [CW-1:0]   ibuf_count_s;
    logic [XLEN-1:0] pcq_head_s;
    logic            pcq_full_s;
    logic            pcq_empty_s;
    logic [CW-1:0]   pcq_count_s;
    logic [CW:0]     credit_used_s;
    logic [CW:0]     credit_limit_s;
    logic            unused_s;

    // Responses with nothing in flight are leftovers from before a reset and are ignored.
    assign gnt_s  = mem_req_o & mem_gnt_i;
    assign rsp_s  = mem_rvalid_i & (outst_r != {CW{1'b0}});
    assign drop_s = rsp_s & (jmp_instr_i | (discard_r != {CW{1'b0}}));
    assign push_s = rsp_s & ~drop_s;
    assign pop_s  = ifu_valid_o & ifu_ready_i;

    // A slot freed by this cycle's pop counts as credit so a 1-cycle memory streams
    // at one word per cycle; buffered plus in-flight words never exceed FIFO_DEPTH.
    assign credit_used_s  = {1'b0, ibuf_count_s} + {1'b0, outst_r};
    assign credit_limit_s = (CW + 1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop_s};
    assign mem_req_o      = ~rst_i & ~jmp_instr_i & (credit_used_s < credit_limit_s);
    assign mem_addr_o     = pc_r;

    // Next in-flight count: grants add, accepted responses retire.
    always_comb begin
        case ({gnt_s, rsp_s})
            2'b10:   outst_next_s = outst_r + CW'(1);
            2'b01:   outst_next_s = outst_r - CW'(1);
            default: outst_next_s = outst_r;
        endcase
    end

    // Fetch PC, in-flight counter and stale-response counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r      <= BOOT_ADDR;
            outst_r   <= {CW{1'b0}};
            discard_r <= {CW{1'b0}};
        end else begin
            outst_r <= outst_next_s;
            if (jmp_instr_i) begin
                pc_r <= word_align(jmp_addr_i);
                // Every response still owed after this edge belongs to the old
                // stream; earlier pending discards are already part of that count.
                discard_r <= outst_next_s;
            end else begin
                if (gnt_s) begin
                    pc_r <= pc_r + XLEN'(4);
                end
                if (rsp_s && (discard_r != {CW{1'b0}})) begin
                    discard_r <= discard_r - CW'(1);
                end
            end
        end
    end

    assign ibuf_din_s.instr = mem_rdata_i;
    assign ibuf_din_s.pc    = pcq_head_s;

    rvj1_fifo #(
        .WIDTH ($bits(ibuf_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (jmp_instr_i),
        .push_i  (push_s),
        .din_i   (ibuf_din_s),
        .pop_i   (pop_s),
        .dout_o  (ibuf_dout_s),
        .full_o  (ibuf_full_s),
        .empty_o (ibuf_empty_s),
        .count_o (ibuf_count_s)
    );

    // PC queue stays aligned with outstanding requests, so it is never flushed by a jump.
    rvj1_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pcq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (gnt_s),
        .din_i   (pc_r),
        .pop_i   (rsp_s),
        .dout_o  (pcq_head_s),
        .full_o  (pcq_full_s),
        .empty_o (pcq_empty_s),
        .count_o (pcq_count_s)
    );

    assign ifu_valid_o = ~ibuf_empty_s & ~jmp_instr_i;
    assign ifu_instr_o = ibuf_empty_s ? NOP_INSTR : ibuf_dout_s.instr;
    assign ifu_pc_o    = ibuf_empty_s ? {XLEN{1'b0}} : ibuf_dout_s.pc;

    assign unused_s = &{1'b0, ibuf_full_s, pcq_full_s, pcq_empty_s, pcq_count_s};

endmodule

// File: tb/tb_rvj1_ifu.sv
// Self-checking bench for rvj1_ifu: memory model with configurable latency,
// in-order stream model of expected fetch addresses and delivered PCs.
module tb_rvj1_ifu;

    localparam logic [31:0] BOOT = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        jmp_instr_i = 1'b0;
    logic [31:0] jmp_addr_i = 32'h0;
    logic [31:0] ifu_instr_o;
    logic [31:0] ifu_pc_o;
    logic        ifu_valid_o;
    logic        ifu_ready_i = 1'b0;

    always #5 clk_i = ~clk_i;

    rvj1_ifu #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .jmp_instr_i  (jmp_instr_i),
        .jmp_addr_i   (jmp_addr_i),
        .ifu_instr_o  (ifu_instr_o),
        .ifu_pc_o     (ifu_pc_o),
        .ifu_valid_o  (ifu_valid_o),
        .ifu_ready_i  (ifu_ready_i)
    );

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    int pops = 0;
    int p0 = 0;
    int last_due = 0;

    bit k_rst = 1'b1;
    bit k_gnt = 1'b1;
    bit k_ready = 1'b1;
    int k_lat = 1;
    bit j_pend = 1'b0;
    logic [31:0] j_addr = 32'h0;

    logic [31:0] mq_addr[$];
    int          mq_due[$];

    logic [31:0] exp_fetch = BOOT;
    logic [31:0] exp_pc = BOOT;

    bit p_rst = 1'b1, p_req = 1'b0, p_gnt = 1'b0, p_jmp = 1'b0, p_valid = 1'b0, p_pop = 1'b0;
    logic [31:0] p_addr = 32'h0;

    // Memory contents: every word is a fixed function of its address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, want);
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] want);
        chk(act === want, name, act, want);
    endtask

    // One clock cycle: drive inputs on the falling edge, sample 1 time unit later,
    // then check against the stream model and update it.
    task automatic cycle();
        bit jmp_now;
        bit pop_now;
        int due;
        @(negedge clk_i);
        rst_i       = k_rst;
        ifu_ready_i = k_ready;
        mem_gnt_i   = k_gnt;
        jmp_instr_i = j_pend;
        jmp_addr_i  = j_addr;
        j_pend      = 1'b0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memfn(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
        jmp_now = jmp_instr_i && !rst_i;
        pop_now = ifu_valid_o && ifu_ready_i && !rst_i;
        if (rst_i) begin
            chk_eq("rst_req_low", {31'b0, mem_req_o}, 32'd0);
            exp_fetch = BOOT;
            exp_pc    = BOOT;
        end else begin
            if (mem_req_o && mem_gnt_i) begin
                chk_eq("fetch_addr", mem_addr_o, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                due = cyc + k_lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq_addr.push_back(mem_addr_o);
                mq_due.push_back(due);
            end
            if (ifu_valid_o) chk_eq("instr_data", ifu_instr_o, memfn(ifu_pc_o));
            if (pop_now) begin
                chk_eq("pop_pc", ifu_pc_o, exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (jmp_now) begin
                chk(!ifu_valid_o && !mem_req_o, "jmp_mask", {30'b0, ifu_valid_o, mem_req_o}, 32'd0);
                exp_fetch = jmp_addr_i & 32'hFFFF_FFFC;
                exp_pc    = jmp_addr_i & 32'hFFFF_FFFC;
            end
            if (!p_rst) begin
                if (p_req && !p_gnt && !p_jmp && !jmp_now)
                    chk(mem_req_o && (mem_addr_o === p_addr), "req_hold", mem_addr_o, p_addr);
                if (p_valid && !p_pop && !jmp_now)
                    chk_eq("valid_hold", {31'b0, ifu_valid_o}, 32'd1);
            end
        end
        p_rst   = rst_i;
        p_req   = mem_req_o;
        p_gnt   = mem_gnt_i;
        p_jmp   = jmp_now;
        p_valid = ifu_valid_o && !rst_i;
        p_pop   = pop_now;
        p_addr  = mem_addr_o;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_req"},   {31'b0, mem_req_o}, 32'd0);
        chk_eq({tag, "_addr"},  mem_addr_o, 32'h8000_0000);
        chk_eq({tag, "_valid"}, {31'b0, ifu_valid_o}, 32'd0);
        chk_eq({tag, "_instr"}, ifu_instr_o, 32'h0000_0013);
        chk_eq({tag, "_pc"},    ifu_pc_o, 32'h0000_0000);
    endtask

    initial begin
        bit found;
        // Reset values.
        run(3);
        chk_reset_outputs("reset");

        // Release: consecutive fetches, first instruction two cycles later.
        k_rst = 1'b0;
        cycle();
        chk_eq("c0_req", {31'b0, mem_req_o}, 32'd1);
        chk_eq("c0_addr", mem_addr_o, 32'h8000_0000);
        chk_eq("c0_valid", {31'b0, ifu_valid_o}, 32'd0);
        cycle();
        chk_eq("c1_addr", mem_addr_o, 32'h8000_0004);
        chk_eq("c1_valid", {31'b0, ifu_valid_o}, 32'd0);
        cycle();
        chk_eq("c2_addr", mem_addr_o, 32'h8000_0008);
        chk_eq("c2_valid", {31'b0, ifu_valid_o}, 32'd1);
        chk_eq("c2_pc", ifu_pc_o, 32'h8000_0000);
        chk_eq("c2_instr", ifu_instr_o, 32'h9357_9BDF);
        p0 = pops;
        run(8);
        chk_eq("throughput_pops", pops - p0, 32'd8);

        // Decoder stall: buffer fills, requests stop, nothing lost afterwards.
        k_ready = 1'b0;
        run(5);
        chk_eq("stall_req_drop", {31'b0, mem_req_o}, 32'd0);
        chk_eq("stall_valid", {31'b0, ifu_valid_o}, 32'd1);
        k_ready = 1'b1;
        p0 = pops;
        run(10);
        chk(pops - p0 >= 8, "post_stall_pops", pops - p0, 32'd8);

        // Grant withheld: request and address held.
        k_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_eq("nogrant_req", {31'b0, mem_req_o}, 32'd1);
        end
        k_gnt = 1'b1;
        run(4);

        // Jump with two requests in flight at latency 3.
        k_lat = 3;
        run(10);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq_addr.size() == 2) found = 1'b1;
            else cycle();
        end
        chk_eq("jump1_two_outstanding", {31'b0, found}, 32'd1);
        j_pend = 1'b1;
        j_addr = 32'h0000_0100;
        cycle();
        cycle();
        chk_eq("jump1_target_addr", mem_addr_o, 32'h0000_0100);
        p0 = pops;
        run(25);
        chk(pops - p0 >= 3, "jump1_resumed", pops - p0, 32'd3);

        // Jump coincident with a response, overridden one cycle later (misaligned target).
        k_lat = 1;
        run(8);
        j_pend = 1'b1;
        j_addr = 32'h0000_0180;
        cycle();
        j_pend = 1'b1;
        j_addr = 32'h0000_0203;
        cycle();
        cycle();
        chk_eq("jump2_req", {31'b0, mem_req_o}, 32'd1);
        chk_eq("jump2_addr", mem_addr_o, 32'h0000_0200);
        p0 = pops;
        run(10);
        chk(pops - p0 >= 5, "jump2_resumed", pops - p0, 32'd5);

        // Reset mid-stream with late responses arriving while reset is held.
        k_lat = 3;
        run(8);
        k_rst = 1'b1;
        run(7);
        chk_reset_outputs("midrst");
        k_rst = 1'b0;
        cycle();
        chk_eq("post_rst_req", {31'b0, mem_req_o}, 32'd1);
        chk_eq("post_rst_addr", mem_addr_o, 32'h8000_0000);
        p0 = pops;
        run(15);
        chk(pops - p0 >= 3, "post_rst_resumed", pops - p0, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
